axi_cmd_master: RTL and testbench

Single-outstanding AXI initiator that turns a simple command/response port into AXI read and write transactions. It drives the 18-bit address / 16-bit data AXI channels of the SRAM AXI responder and any peer with identical channel widths. Typical masters are a debug/UART bridge or a test pattern engine. The block has a timeout watchdog and discards stray response beats.

---
 rtl/axi_cmd_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_master.sv
// rtl/axi_cmd_master.sv - single-outstanding command port to AXI initiator
//
// Turns one command at a time into an AXI write (AW + W, then B) or read
// (AR, then R) and returns one response. A watchdog ends a transaction that
// gets no beat in time. B/R beats arriving while idle are drained and counted.
//
// Ports:
//   a_clk, a_rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_we,
//   cmd_addr, cmd_wdata, cmd_be      command in (we=1 write, we=0 read)
//   rsp_valid/rsp_ready, rsp_we,
//   rsp_rdata, rsp_err               response out (err on timeout or resp=1)
//   stray_cnt                        saturating count of beats dropped in idle
//   aw_*, w_*, b_*, ar_*, r_*        AXI initiator channels (18-bit addr, 16-bit data)
module axi_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             a_clk,
    input  logic             a_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [17:0]      cmd_addr,
    input  logic [15:0]      cmd_wdata,
    input  logic [1:0]       cmd_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_we,
    output logic [15:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [CNT_W-1:0] stray_cnt,
    output logic             aw_valid,
    input  logic             aw_ready,
    output logic [17:0]      aw_addr,
    output logic [2:0]       aw_prot,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [15:0]      w_data,
    output logic [1:0]       w_strb,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_resp,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [17:0]      ar_addr,
    output logic [2:0]       ar_prot,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [15:0]      r_data,
    input  logic             r_resp
);
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_we_q, rsp_we_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] stray_q, stray_d;
    logic             aw_valid_q, aw_valid_d;
    logic [17:0]      aw_addr_q, aw_addr_d;
    logic             w_valid_q, w_valid_d;
    logic [15:0]      w_data_q, w_data_d;
    logic [1:0]       w_strb_q, w_strb_d;
    logic             b_ready_q, b_ready_d;
    logic             ar_valid_q, ar_valid_d;
    logic [17:0]      ar_addr_q, ar_addr_d;
    logic             r_ready_q, r_ready_d;

    logic             b_beat, r_beat, beat_take, active, to_hit;
    logic [CNT_W:0]   stray_sum;

    assign b_beat    = b_valid & b_ready_q;
    assign r_beat    = r_valid & r_ready_q;
    assign active    = state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP};
    // A response beat taken in the same cycle as the timeout wins.
    assign beat_take = ((state_q == S_WR_RESP) & b_beat) | ((state_q == S_RD_RESP) & r_beat);
    assign to_hit    = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT));
    // One extra bit so two simultaneous stray beats still saturate correctly.
    assign stray_sum = {1'b0, stray_q} + {{CNT_W{1'b0}}, b_beat} + {{CNT_W{1'b0}}, r_beat};

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q     <= S_IDLE;
            to_q        <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= '0;
            aw_valid_q  <= 1'b0;
            aw_addr_q   <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            r_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_q        <= to_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            stray_q     <= stray_d;
            aw_valid_q  <= aw_valid_d;
            aw_addr_q   <= aw_addr_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            r_ready_q   <= r_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_d        = to_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        stray_d     = stray_q;
        aw_valid_d  = aw_valid_q;
        aw_addr_d   = aw_addr_q;
        w_valid_d   = w_valid_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;

        if (active) begin
            to_d = to_q + TO_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (b_beat | r_beat) begin
                    stray_d = stray_sum[CNT_W] ? '1 : stray_sum[CNT_W-1:0];
                end
                if (cmd_valid & cmd_ready_q) begin
                    to_d     = '0;
                    rsp_we_d = cmd_we;
                    if (cmd_we) begin
                        aw_addr_d  = cmd_addr;
                        w_data_d   = cmd_wdata;
                        w_strb_d   = cmd_be;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = S_WR_REQ;
                    end else begin
                        ar_addr_d  = cmd_addr;
                        ar_valid_d = 1'b1;
                        state_d    = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; move on once both are gone.
                aw_valid_d = aw_valid_q & ~aw_ready;
                w_valid_d  = w_valid_q & ~w_ready;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_beat) begin
                    rsp_err_d   = b_resp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (r_beat) begin
                    rsp_err_d   = r_resp;
                    rsp_rdata_d = r_data;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (active && to_hit && !beat_take) begin
            aw_valid_d  = 1'b0;
            w_valid_d   = 1'b0;
            ar_valid_d  = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
        end

        // Ready outputs are registered, so they are derived from the next state.
        cmd_ready_d = (state_d == S_IDLE);
        b_ready_d   = (state_d == S_IDLE) || (state_d == S_WR_RESP);
        r_ready_d   = (state_d == S_IDLE) || (state_d == S_RD_RESP);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign stray_cnt = stray_q;
    assign aw_valid  = aw_valid_q;
    assign aw_addr   = aw_addr_q;
    assign aw_prot   = 3'b000;
    assign w_valid   = w_valid_q;
    assign w_data    = w_data_q;
    assign w_strb    = w_strb_q;
    assign b_ready   = b_ready_q;
    assign ar_valid  = ar_valid_q;
    assign ar_addr   = ar_addr_q;
    assign ar_prot   = 3'b000;
    assign r_ready   = r_ready_q;
endmodule

// File: tb/tb_axi_cmd_master.sv
// tb/tb_axi_cmd_master.sv - self-checking bench for axi_cmd_master
module tb_axi_cmd_master;
    localparam int T = 8;

    logic        a_clk = 1'b0;
    logic        a_rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [17:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [1:0]  cmd_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_we, rsp_err;
    logic [15:0] rsp_rdata;
    logic [7:0]  stray_cnt;
    logic        aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0;
    logic [17:0] aw_addr, ar_addr;
    logic [2:0]  aw_prot, ar_prot;
    logic [15:0] w_data, r_data = '0;
    logic [1:0]  w_strb;
    logic        b_valid = 1'b0, b_ready, b_resp = 1'b0;
    logic        ar_valid, ar_ready = 1'b0, r_valid = 1'b0, r_ready, r_resp = 1'b0;

    axi_cmd_master #(.TIMEOUT(T), .CNT_W(8)) u_dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stray_cnt(stray_cnt),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          s1;     // aw_ready / ar_ready stall
        int          s2;     // w_ready stall
        int          lat;    // B/R beat latency after the request phase
        logic        resp;
        int          hold;   // cycles rsp_ready is held low
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat; // cycles from accept edge to rsp_valid
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] mem [int];      // responder storage
    logic [15:0] ref_mem [int];  // reference model storage

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    task automatic ref_wr(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        ref_mem[int'(a)] = merge(ref_rd(a), d, be);
    endtask

    task automatic tick;
        @(posedge a_clk);
        #1;
    endtask

    // Issues one command, plays the AXI responder cycle by cycle, then checks
    // the response and retires it after v.hold cycles of backpressure.
    task automatic run_cmd(input vec_t v, input string tag);
        int c = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, pc = 0;
        bit b_pend = 0, r_pend = 0, wr_done = 0, got = 0;
        bit prev_aw = 0, prev_w = 0, prev_ar = 0;
        logic [17:0] cap_aw = '0, cap_ar = '0;
        logic [15:0] cap_w = '0;
        logic [1:0]  cap_s = '0;
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_be = v.be;
        tick();
        cmd_valid = 1'b0;
        while (!got && c < 40) begin
            if (rsp_valid) begin
                got = 1;
                aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
            end else begin
                chk({tag, "_busy_cmd_ready"}, 32'(cmd_ready), 32'd0);
                if (prev_aw) chk({tag, "_aw_held"}, 32'({aw_valid, aw_addr}), 32'({1'b1, v.addr}));
                if (prev_w)  chk({tag, "_w_held"}, 32'({w_valid, w_strb, w_data}), 32'({1'b1, v.be, v.wdata}));
                if (prev_ar) chk({tag, "_ar_held"}, 32'({ar_valid, ar_addr}), 32'({1'b1, v.addr}));
                b_valid = b_pend && (pc >= v.lat);
                r_valid = r_pend && (pc >= v.lat);
                b_resp = v.resp; r_resp = v.resp;
                r_data = mem_rd(cap_ar);
                if (b_pend || r_pend) pc++;
                aw_ready = (c >= v.s1);
                w_ready  = (c >= v.s2);
                ar_ready = (c >= v.s1);
                if (aw_valid && aw_ready) begin
                    aw_hs++; cap_aw = aw_addr;
                    chk({tag, "_aw_addr"}, 32'(aw_addr), 32'(v.addr));
                end
                if (w_valid && w_ready) begin
                    w_hs++; cap_w = w_data; cap_s = w_strb;
                    chk({tag, "_w_beat"}, 32'({w_strb, w_data}), 32'({v.be, v.wdata}));
                end
                if (ar_valid && ar_ready) begin
                    ar_hs++; cap_ar = ar_addr; r_pend = 1; pc = 0;
                    chk({tag, "_ar_addr"}, 32'(ar_addr), 32'(v.addr));
                end
                if (!wr_done && aw_hs > 0 && w_hs > 0) begin
                    wr_done = 1; b_pend = 1; pc = 0;
                    mem[int'(cap_aw)] = merge(mem_rd(cap_aw), cap_w, cap_s);
                end
                if (b_valid && b_ready) b_pend = 0;
                if (r_valid && r_ready) r_pend = 0;
                prev_aw = aw_valid && !aw_ready;
                prev_w  = w_valid && !w_ready;
                prev_ar = ar_valid && !ar_ready;
                tick();
                c++;
            end
        end
        chk({tag, "_rsp_arrived"}, 32'(got), 32'd1);
        if (!got) return;
        chk({tag, "_latency"}, 32'(c), 32'(v.exp_lat));
        chk({tag, "_rsp"}, 32'({rsp_we, rsp_err, rsp_rdata}), 32'({v.we, v.exp_err, v.exp_rdata}));
        chk({tag, "_valids_low"}, 32'({aw_valid, w_valid, ar_valid, cmd_ready}), 32'd0);
        chk({tag, "_hs_count"}, 32'({aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}),
            v.we ? 32'h010100 : 32'h000001);
        if (v.we) chk({tag, "_mem"}, 32'(mem_rd(v.addr)), 32'(merge(ref_rd(v.addr), v.wdata, v.be)));
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1; cmd_we = ~v.we; cmd_addr = 18'h00003;
            tick();
            chk({tag, "_hold_rsp"}, 32'({rsp_valid, rsp_we, rsp_err, rsp_rdata}),
                32'({1'b1, v.we, v.exp_err, v.exp_rdata}));
            chk({tag, "_hold_idle"}, 32'({cmd_ready, aw_valid, w_valid, ar_valid}), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({tag, "_release"}, 32'({rsp_valid, cmd_ready, aw_valid, w_valid, ar_valid}), 32'b01000);
    endtask

    vec_t vt[10];

    initial begin
        vec_t v;
        int s, s1, s2, lat;
        logic [17:0] a;

        vt[0] = '{1'b1, 18'h00012, 16'hBEEF, 2'b11, 0, 0, 0, 1'b0, 0,  16'h0000, 1'b0, 2};
        vt[1] = '{1'b0, 18'h00012, 16'h0000, 2'b00, 0, 0, 0, 1'b0, 0,  16'hBEEF, 1'b0, 2};
        vt[2] = '{1'b0, 18'h00345, 16'h0000, 2'b00, 1, 0, 2, 1'b0, 0,  16'hA6E0, 1'b0, 5};
        vt[3] = '{1'b1, 18'h00020, 16'h1234, 2'b01, 2, 1, 1, 1'b0, 1,  16'h0000, 1'b0, 5};
        vt[4] = '{1'b0, 18'h00020, 16'h0000, 2'b00, 0, 0, 0, 1'b0, 0,  16'hA534, 1'b0, 2};
        vt[5] = '{1'b1, 18'h00030, 16'h5555, 2'b11, 0, 0, 0, 1'b1, 0,  16'h0000, 1'b1, 2};
        vt[6] = '{1'b0, 18'h00030, 16'h0000, 2'b00, 0, 0, 0, 1'b1, 0,  16'h5555, 1'b1, 2};
        vt[7] = '{1'b1, 18'h3FFFF, 16'hA5A5, 2'b10, 0, 0, 7, 1'b0, 0,  16'h0000, 1'b0, 9};
        vt[8] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 0, 0, 0, 1'b0, 10, 16'hA55A, 1'b0, 2};
        vt[9] = '{1'b0, 18'h00012, 16'h0000, 2'b00, 3, 0, 4, 1'b0, 2,  16'hBEEF, 1'b0, 9};

        // Reset state
        repeat (3) @(posedge a_clk);
        #1;
        chk("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_we, rsp_err, aw_valid, w_valid,
                                  ar_valid, b_ready, r_ready}), 32'd0);
        chk("reset_data", 32'({rsp_rdata, stray_cnt}), 32'd0);
        chk("reset_bus", 32'({aw_addr, w_strb}), 32'd0);
        chk("reset_bus2", 32'({ar_addr, w_data[7:0]}), 32'd0);
        chk("reset_wdata_hi", 32'(w_data[15:8]), 32'd0);
        chk("prot_tied", 32'({aw_prot, ar_prot}), 32'd0);
        a_rst = 1'b0;
        tick();
        chk("post_reset_ready", 32'({cmd_ready, b_ready, r_ready}), 32'b111);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_cmd(vt[i], $sformatf("vec%0d", i));
            if (vt[i].we) ref_wr(vt[i].addr, vt[i].wdata, vt[i].be);
        end

        // Skewed handshakes: aw_ready three cycles ahead of w_ready
        for (int i = 0; i < 5; i++) begin
            s = $urandom_range(0, 4);
            v = '{1'b1, 18'h00100 + 18'(i), 16'($urandom), 2'b11, s, s + 3, 0, 1'b0, 0,
                  16'h0000, 1'b0, s + 5};
            run_cmd(v, $sformatf("skew%0d", i));
            ref_wr(v.addr, v.wdata, v.be);
        end

        // Randomized commands against the reference model
        for (int i = 0; i < 30; i++) begin
            s1 = $urandom_range(0, 3);
            s2 = $urandom_range(0, 3);
            lat = $urandom_range(0, 3);
            a = 18'($urandom_range(0, 15));
            v.we = 1'($urandom_range(0, 1));
            v.addr = a;
            v.wdata = 16'($urandom);
            v.be = 2'($urandom);
            v.s1 = s1; v.s2 = s2; v.lat = lat;
            v.resp = ($urandom_range(0, 7) == 0);
            v.hold = $urandom_range(0, 3);
            v.exp_rdata = v.we ? 16'h0000 : ref_rd(a);
            v.exp_err = v.resp;
            v.exp_lat = 2 + lat + (v.we ? ((s1 > s2) ? s1 : s2) : s1);
            run_cmd(v, $sformatf("rnd%0d", i));
            if (v.we) ref_wr(v.addr, v.wdata, v.be);
        end

        // Timeout: B never arrives, then a late B is drained as a stray
        v = '{1'b1, 18'h00050, 16'h0F0F, 2'b11, 0, 0, 1000, 1'b0, 0, 16'h0000, 1'b1, T + 1};
        run_cmd(v, "timeout");
        ref_wr(v.addr, v.wdata, v.be);
        chk("stray_before", 32'(stray_cnt), 32'd0);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("stray_after_late_b", 32'({stray_cnt, rsp_valid}), 32'({8'd1, 1'b0}));
        tick();
        chk("no_rsp_after_stray", 32'({rsp_valid, cmd_ready}), 32'b01);

        // Reset while waiting for R
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 18'h00012;
        tick();
        cmd_valid = 1'b0;
        chk("rst_ar_valid", 32'(ar_valid), 32'd1);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        chk("rst_in_rd_resp", 32'({ar_valid, r_ready}), 32'b01);
        a_rst = 1'b1;
        tick();
        chk("rst_mid_valids", 32'({aw_valid, w_valid, ar_valid, rsp_valid, cmd_ready, b_ready, r_ready}), 32'd0);
        chk("rst_mid_stray", 32'(stray_cnt), 32'd0);
        a_rst = 1'b0;
        tick();
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        r_valid = 1'b1; r_data = 16'h7777;
        tick();
        r_valid = 1'b0;
        chk("rst_late_r_stray", 32'({stray_cnt, rsp_valid}), 32'({8'd1, 1'b0}));
        v = '{1'b0, 18'h00012, 16'h0000, 2'b00, 0, 0, 0, 1'b0, 0, 16'hBEEF, 1'b0, 2};
        run_cmd(v, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
